// File: rtl/if_stage.sv
//------------------------------------------------------------------------------
// Module      : if_stage
// Description : Instruction-fetch stage. Owns the PC, drives the 1-cycle-latency
//               inst SRAM, buffers the fetched instruction while decode stalls
//               and honours branch redirects from decode.
//               Optional macro IF_ADEF_EN: suppress misaligned fetches, flag fs_adef.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
`ifdef IF_ADEF_EN
    ,
    output logic        fs_adef
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_fs_pc;
    logic [31:0] r_inst_buf;
    logic [31:0] w_seq_pc;
    logic [31:0] w_nextpc;
    logic [31:0] w_fs_inst;
    logic        w_fs_allowin;
    logic        w_fetch_go;
    logic        w_addr_ok;
    logic        w_buf_load;
`ifdef IF_ADEF_EN
    logic        r_adef;
`endif

    always_comb begin
        w_seq_pc       = r_fs_pc + 32'd4;
        w_nextpc       = br_taken ? br_target : w_seq_pc;
        fs_to_ds_valid = (r_state != S_IDLE) & ~br_taken;
        w_fs_allowin   = (r_state == S_IDLE) | (fs_to_ds_valid & ds_allowin) | br_taken;
        // The stage advances even when the SRAM request itself is suppressed.
        w_fetch_go     = ~reset & w_fs_allowin;
`ifdef IF_ADEF_EN
        w_addr_ok      = (w_nextpc[1:0] == 2'b00);
`else
        w_addr_ok      = 1'b1;
`endif
        inst_sram_en    = w_fetch_go & w_addr_ok;
        inst_sram_addr  = w_nextpc;
        inst_sram_we    = 4'h0;
        inst_sram_wdata = 32'h0;
        w_buf_load      = ~w_fetch_go & (r_state == S_FETCH);
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_fetch_go) begin
            w_state_nxt = S_FETCH;
        end else if (r_state == S_FETCH) begin
            w_state_nxt = S_HOLD;
        end
    end

    always_comb begin
        w_fs_inst = (r_state == S_HOLD) ? r_inst_buf : inst_sram_rdata;
`ifdef IF_ADEF_EN
        if (r_adef) begin
            w_fs_inst = 32'h0;
        end
`endif
        fs_to_ds_bus = (r_state == S_IDLE) ? 64'd0 : {r_fs_pc, w_fs_inst};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fs_pc    <= RESET_PC - 32'd4;
            r_inst_buf <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fetch_go) begin
                r_fs_pc <= w_nextpc;
            end
            // Capture rdata on the only edge it is guaranteed valid.
            if (w_buf_load) begin
                r_inst_buf <= inst_sram_rdata;
            end
        end
    end

`ifdef IF_ADEF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_adef <= 1'b0;
        end else if (w_fetch_go) begin
            r_adef <= ~w_addr_ok;
        end
    end

    assign fs_adef = r_adef;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage against a one-slot pipeline
//               model with a behavioural SRAM returning noise when not read.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] C_RESET_PC = 32'h1c000000;

    logic        clk;
    logic        reset;
    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
`ifdef IF_ADEF_EN
    logic        fs_adef;
`endif

    int errors = 0;
    int checks = 0;

    // Model: one slot holding the instruction presented to decode.
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_adef;
    logic        e_req;
    logic        e_ok;
    logic [31:0] e_addr;

    if_stage #(.RESET_PC(C_RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .ds_allowin      (ds_allowin),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
`ifdef IF_ADEF_EN
        ,
        .fs_adef         (fs_adef)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h1c000008) return 32'h02800421;
        return ({a[15:0], 16'h0} ^ ~a) ^ 32'h13579bdf;
    endfunction

    // rdata is only meaningful the cycle after a request; otherwise noise.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= mem(inst_sram_addr);
        else              inst_sram_rdata <= $urandom();
    end

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = C_RESET_PC - 32'd4;
        m_inst  = 32'h0;
        m_adef  = 1'b0;
    endtask

    // Apply inputs for one cycle and compare all outputs against the model.
    task automatic drive(input logic a, input logic b, input logic [31:0] t);
        logic e_valid;
        ds_allowin = a;
        br_taken   = b;
        br_target  = t;
        #1;
        e_valid = m_valid & ~b;
        e_req   = ~m_valid | (e_valid & a) | b;
        e_addr  = b ? t : m_pc + 32'd4;
`ifdef IF_ADEF_EN
        e_ok    = (e_addr[1:0] == 2'b00);
`else
        e_ok    = 1'b1;
`endif
        checks++;
        if (fs_to_ds_valid !== e_valid) begin
            errors++;
            $display("FAIL valid t=%0t got=%b exp=%b", $time, fs_to_ds_valid, e_valid);
        end
        checks++;
        if (inst_sram_en !== (e_req & e_ok)) begin
            errors++;
            $display("FAIL sram_en t=%0t got=%b exp=%b", $time, inst_sram_en, e_req & e_ok);
        end
        if (e_req & e_ok) begin
            checks++;
            if (inst_sram_addr !== e_addr) begin
                errors++;
                $display("FAIL sram_addr t=%0t got=%h exp=%h", $time, inst_sram_addr, e_addr);
            end
        end
        if (e_valid) begin
            checks++;
            if (fs_to_ds_bus !== {m_pc, m_inst}) begin
                errors++;
                $display("FAIL bus t=%0t got=%h exp=%h", $time, fs_to_ds_bus, {m_pc, m_inst});
            end
`ifdef IF_ADEF_EN
            checks++;
            if (fs_adef !== m_adef) begin
                errors++;
                $display("FAIL adef t=%0t got=%b exp=%b", $time, fs_adef, m_adef);
            end
`endif
        end
        checks++;
        if (inst_sram_we !== 4'h0 || inst_sram_wdata !== 32'h0) begin
            errors++;
            $display("FAIL sram_write t=%0t we=%h wdata=%h exp=0", $time, inst_sram_we, inst_sram_wdata);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (e_req) begin
            m_valid = 1'b1;
            m_pc    = e_addr;
            m_inst  = e_ok ? mem(e_addr) : 32'h0;
            m_adef  = ~e_ok;
        end
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; ds_allowin = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b0 || fs_to_ds_bus !== 64'd0) begin
            errors++;
            $display("FAIL reset_state valid=%b en=%b bus=%h exp=0/0/0", fs_to_ds_valid, inst_sram_en, fs_to_ds_bus);
        end
        release_reset();
    endtask

    task automatic test_first_fetch();
        drive(1'b1, 1'b0, 32'h0);
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000000) begin
            errors++;
            $display("FAIL first_req en=%b addr=%h exp=1/1c000000", inst_sram_en, inst_sram_addr);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0);
            checks++;
            if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[63:32] !== 32'h1c000000 + 32'(4 * i)) begin
                errors++;
                $display("FAIL seq_pc[%0d] valid=%b pc=%h exp pc=%h", i, fs_to_ds_valid,
                         fs_to_ds_bus[63:32], 32'h1c000000 + 32'(4 * i));
            end
            if (i < 2) tick();
        end
    endtask

    // Entered with pc 0x1c000008 on the bus and not yet handshaken.
    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            checks++;
            if (fs_to_ds_bus !== {32'h1c000008, 32'h02800421} || inst_sram_en !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d] bus=%h en=%b exp=1c00000802800421/0", i, fs_to_ds_bus, inst_sram_en);
            end
            tick();
        end
        drive(1'b1, 1'b0, 32'h0);
        checks++;
        if (inst_sram_addr !== 32'h1c00000c) begin
            errors++;
            $display("FAIL stall_release addr=%h exp=1c00000c", inst_sram_addr);
        end
        tick();
    endtask

    task automatic test_branch();
        drive(1'b1, 1'b1, 32'h1c000100);
        checks++;
        if (fs_to_ds_valid !== 1'b0 || inst_sram_addr !== 32'h1c000100) begin
            errors++;
            $display("FAIL br_cancel valid=%b addr=%h exp=0/1c000100", fs_to_ds_valid, inst_sram_addr);
        end
        tick();
        drive(1'b1, 1'b0, 32'h0);
        checks++;
        if (fs_to_ds_bus[63:32] !== 32'h1c000100) begin
            errors++;
            $display("FAIL br_pc pc=%h exp=1c000100", fs_to_ds_bus[63:32]);
        end
        tick();
    endtask

    task automatic test_branch_hold();
        repeat (2) begin
            drive(1'b0, 1'b0, 32'h0);
            tick();
        end
        drive(1'b0, 1'b1, 32'h1c000240);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        checks++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {32'h1c000240, mem(32'h1c000240)}) begin
            errors++;
            $display("FAIL br_hold valid=%b bus=%h exp bus=%h", fs_to_ds_valid, fs_to_ds_bus,
                     {32'h1c000240, mem(32'h1c000240)});
        end
        tick();
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 32'hfffffffc);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        checks++;
        if (inst_sram_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr addr=%h exp=00000000", inst_sram_addr);
        end
        tick();
        drive(1'b1, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_reset_mid_hold();
        repeat (2) begin
            drive(1'b0, 1'b0, 32'h0);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b0 || fs_to_ds_bus !== 64'd0) begin
            errors++;
            $display("FAIL async_reset valid=%b en=%b bus=%h exp=0/0/0", fs_to_ds_valid, inst_sram_en, fs_to_ds_bus);
        end
        @(posedge clk);
        release_reset();
        drive(1'b1, 1'b0, 32'h0);
        checks++;
        if (inst_sram_addr !== C_RESET_PC) begin
            errors++;
            $display("FAIL refetch addr=%h exp=%h", inst_sram_addr, C_RESET_PC);
        end
        tick();
    endtask

`ifdef IF_ADEF_EN
    task automatic test_adef();
        drive(1'b1, 1'b1, 32'h1c000102);
        checks++;
        if (inst_sram_en !== 1'b0) begin
            errors++;
            $display("FAIL adef_no_req en=%b exp=0", inst_sram_en);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0);
        checks++;
        if (fs_to_ds_valid !== 1'b1 || fs_adef !== 1'b1 || fs_to_ds_bus !== {32'h1c000102, 32'h0}) begin
            errors++;
            $display("FAIL adef_out valid=%b adef=%b bus=%h exp=1/1/1c00010200000000",
                     fs_to_ds_valid, fs_adef, fs_to_ds_bus);
        end
        tick();
        drive(1'b1, 1'b1, 32'h1c000200);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        tick();
    endtask
`endif

    task automatic test_random();
        logic [31:0] t;
        for (int i = 0; i < 400; i++) begin
            t = $urandom();
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            drive($urandom_range(9) < 7, $urandom_range(7) == 0, t);
            tick();
        end
    endtask

    initial begin
        inst_sram_rdata = 32'h0;
        test_reset();
        test_first_fetch();
        test_stall();
        test_branch();
        test_branch_hold();
        test_wrap();
        test_reset_mid_hold();
`ifdef IF_ADEF_EN
        test_adef();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage LoongArch pipeline that replaces the single-cycle top.
- Owns the PC and drives the synchronous inst SRAM, which has 1-cycle read latency.
- Hands {pc, inst} to the decode stage through a valid/allowin handshake.
- Accepts redirects (branch/jump) from decode and buffers the fetched instruction while decode stalls.

Parameters:
- RESET_PC, 32'h1c000000, address of the first fetch after reset release.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ds_allowin  input  1  decode can accept an instruction this cycle.
- br_taken  input  1  decode redirect request, sampled every cycle.
- br_target  input  32  redirect address, valid when br_taken=1.
- fs_to_ds_valid  output  1  {pc, inst} on fs_to_ds_bus is valid.
- fs_to_ds_bus  output  64  [63:32]=pc, [31:0]=inst.
- inst_sram_en  output  1  read request.
- inst_sram_we  output  4  tied 4'h0.
- inst_sram_addr  output  32  fetch address (nextpc).
- inst_sram_wdata  output  32  tied 0.
- inst_sram_rdata  input  32  read data, valid the cycle after the request.
- fs_adef  output  1  present only with IF_ADEF_EN (see Optional Feature).

Behaviour:
- Reset (async, immediate):
  - fs_pc=RESET_PC-4.
  - state=IDLE.
  - inst_buf=0.
  - fs_to_ds_valid=0, fs_to_ds_bus=0.
  - inst_sram_en=0.
- State machine over {fs_valid, buf_valid}:
  - IDLE: no instruction held.
  - FETCH: instruction in flight on inst_sram_rdata.
  - HOLD: instruction captured in inst_buf.
- Combinational signals:
  - to_fs_valid = ~reset.
  - seq_pc = fs_pc+4.
  - nextpc = br_taken ? br_target : seq_pc.
  - fs_ready_go = 1.
  - fs_allowin = (state==IDLE) | (fs_to_ds_valid & ds_allowin) | br_taken.
  - inst_sram_en = to_fs_valid & fs_allowin.
  - inst_sram_addr = nextpc.
- PC update: when inst_sram_en, fs_pc<=nextpc. Otherwise fs_pc holds.
- Transitions:
  - IDLE -> FETCH when inst_sram_en.
  - FETCH -> FETCH when the handshake completes (fs_to_ds_valid & ds_allowin) and a new request issues; same for br_taken.
  - FETCH -> HOLD when ~ds_allowin & ~br_taken; inst_buf<=inst_sram_rdata on that edge.
  - HOLD -> FETCH on handshake or br_taken (new request issued); inst_buf is discarded.
  - HOLD -> HOLD while ~ds_allowin & ~br_taken.
- Outputs:
  - fs_inst = (state==HOLD) ? inst_buf : inst_sram_rdata.
  - fs_to_ds_valid = (state!=IDLE) & ~br_taken.
  - fs_to_ds_bus = {fs_pc, fs_inst}.
- First fetch: the cycle after reset deasserts, the stage requests addr RESET_PC. fs_to_ds_valid rises the following cycle with pc=RESET_PC.
- Redirect: the instruction currently in IF is wrong-path.
  - It is cancelled the same cycle (fs_to_ds_valid=0) even if ds_allowin=1.
  - br_target is requested in that cycle; the next cycle presents {br_target, inst}.
- Simultaneous br_taken and ~ds_allowin: the redirect wins, the buffer is dropped and the new fetch issues.
- Back-to-back handshakes sustain 1 instruction/cycle, with sequential pc values +4 apart.
- No SRAM request is issued while the stage is full and decode is stalled; inst_sram_addr is a don't-care when inst_sram_en=0.
- Reset mid-stall: state returns to IDLE immediately and the buffered instruction is lost; refetch starts at RESET_PC.
- Address wrap: seq_pc wraps modulo 2^32 with no flag.

Optional Feature:
- Macro: IF_ADEF_EN.
- When defined:
  - A nextpc with [1:0]!=0 is not sent to the SRAM (inst_sram_en forced 0 for that address).
  - The stage still advances to FETCH with fs_adef<=1, and inst is forced to 32'h0.
  - fs_adef clears on the next accepted request and is reset to 0.
- When undefined: the fs_adef port is absent, and misaligned addresses are fetched as-is with the low bits passed to the SRAM.

Test Plan:
- Release reset, ds_allowin=1 → first request addr 0x1c000000, then fs_to_ds_valid=1 with pc 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles.
- ds_allowin=0 for 3 cycles while pc=0x1c000008 is valid with rdata 0x02800421 → the bus holds {0x1c000008, 0x02800421} for all 3 cycles and inst_sram_en=0; on release the next pc is 0x1c00000c.
- br_taken=1, br_target=0x1c000100 while FETCH → fs_to_ds_valid=0 that cycle, addr=0x1c000100; the next cycle pc=0x1c000100.
- br_taken=1 during HOLD with ds_allowin=0 → the buffer is discarded; the next valid pc is br_target.
- Assert reset asynchronously mid-HOLD → fs_to_ds_valid drops immediately with no clock edge; after release, refetch from 0x1c000000.
- With IF_ADEF_EN, br_target=0x1c000102 → no SRAM request, then fs_to_ds_valid=1 with fs_adef=1 and inst=0.
